// File: rtl/in_order_resp_reorder_buffer.sv
// In-order response reorder buffer: hands out sequential IDs, collects
// out-of-order responses by ID and retires them strictly in issue order.
module in_order_resp_reorder_buffer #(
    parameter  int unsigned DEPTH  = 64,
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned ID_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    output logic [ID_W-1:0]   alloc_id,
    input  logic              resp_valid,
    input  logic [ID_W-1:0]   resp_id,
    input  logic [DATA_W-1:0] resp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ID_W-1:0]   out_id,
    output logic [DATA_W-1:0] out_data,
    output logic              senior_valid,
    output logic [ID_W-1:0]   most_senior_id,
    output logic [ID_W:0]     outstanding,
    output logic              err_unexp_resp
);

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_PENDING = 2'd1,
        SLOT_DONE    = 2'd2
    } slot_e;

    slot_e             slot_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [ID_W:0]     head_q, head_d;
    logic [ID_W:0]     tail_q, tail_d;
    logic              err_q;

    logic [ID_W-1:0]   head_idx;
    logic [ID_W-1:0]   tail_idx;
    logic              empty;
    logic              alloc_fire;
    logic              resp_hit;
    logic              retire_fire;

    assign head_idx    = head_q[ID_W-1:0];
    assign tail_idx    = tail_q[ID_W-1:0];
    assign outstanding = tail_q - head_q;
    assign empty       = (outstanding == '0);

    // Handshake qualifiers, all decided from pre-edge registered state
    assign alloc_ready = (outstanding != (ID_W+1)'(DEPTH));
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign resp_hit    = resp_valid && (slot_q[resp_id] == SLOT_PENDING);
    assign out_valid   = !empty && (slot_q[head_idx] == SLOT_DONE);
    assign retire_fire = out_valid && out_ready;

    assign alloc_id       = tail_idx;
    assign out_id         = head_idx;
    assign out_data       = data_q[head_idx];
    assign senior_valid   = !empty;
    assign most_senior_id = head_idx;
    assign err_unexp_resp = err_q;

    // Next pointer values: each advances by at most one per cycle
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (retire_fire) begin
            head_d = head_q + (ID_W+1)'(1);
        end
        if (alloc_fire) begin
            tail_d = tail_q + (ID_W+1)'(1);
        end
    end

    // Pointer and error-pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            err_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            err_q  <= resp_valid && !resp_hit;
        end
    end

    // Slot lifecycle; alloc, resp and retire always touch distinct slots
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_q[i] <= SLOT_FREE;
            end
        end else begin
            if (alloc_fire) begin
                slot_q[tail_idx] <= SLOT_PENDING;
            end
            if (resp_hit) begin
                slot_q[resp_id] <= SLOT_DONE;
            end
            if (retire_fire) begin
                slot_q[head_idx] <= SLOT_FREE;
            end
        end
    end

    // Payload storage, written only by accepted responses; never cleared
    always_ff @(posedge clk) begin
        if (resp_hit) begin
            data_q[resp_id] <= resp_data;
        end
    end

endmodule

// File: tb/tb_in_order_resp_reorder_buffer.sv
// Directed bench for in_order_resp_reorder_buffer (DEPTH=8).
module tb_in_order_resp_reorder_buffer;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              alloc_valid = 1'b0;
    logic              alloc_ready;
    logic [ID_W-1:0]   alloc_id;
    logic              resp_valid = 1'b0;
    logic [ID_W-1:0]   resp_id = '0;
    logic [DATA_W-1:0] resp_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ID_W-1:0]   out_id;
    logic [DATA_W-1:0] out_data;
    logic              senior_valid;
    logic [ID_W-1:0]   most_senior_id;
    logic [ID_W:0]     outstanding;
    logic              err_unexp_resp;

    int tests  = 0;
    int failed = 0;

    in_order_resp_reorder_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .alloc_valid    (alloc_valid),
        .alloc_ready    (alloc_ready),
        .alloc_id       (alloc_id),
        .resp_valid     (resp_valid),
        .resp_id        (resp_id),
        .resp_data      (resp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_id         (out_id),
        .out_data       (out_data),
        .senior_valid   (senior_valid),
        .most_senior_id (most_senior_id),
        .outstanding    (outstanding),
        .err_unexp_resp (err_unexp_resp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alloc_valid = 1'b0;
        resp_valid  = 1'b0;
        resp_id     = '0;
        resp_data   = '0;
        out_ready   = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        tests++; if (alloc_ready !== 1'b1) begin failed++; $display("FAIL reset_alloc_ready got=%b exp=1", alloc_ready); end
        tests++; if (alloc_id !== 3'd0) begin failed++; $display("FAIL reset_alloc_id got=%0d exp=0", alloc_id); end
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests++; if (senior_valid !== 1'b0) begin failed++; $display("FAIL reset_senior_valid got=%b exp=0", senior_valid); end
        tests++; if (most_senior_id !== 3'd0) begin failed++; $display("FAIL reset_senior_id got=%0d exp=0", most_senior_id); end
        tests++; if (outstanding !== 4'd0) begin failed++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
        tests++; if (err_unexp_resp !== 1'b0) begin failed++; $display("FAIL reset_err got=%b exp=0", err_unexp_resp); end
    endtask

    task automatic test_in_order();
        apply_reset();
        out_ready   = 1'b1;
        alloc_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++; if (alloc_id !== ID_W'(i)) begin failed++; $display("FAIL inord_alloc_id got=%0d exp=%0d", alloc_id, i); end
            tick();
        end
        alloc_valid = 1'b0;
        tests++; if (outstanding !== 4'd4) begin failed++; $display("FAIL inord_outstanding got=%0d exp=4", outstanding); end
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL inord_early_valid got=%b exp=0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            resp_valid = 1'b1;
            resp_id    = ID_W'(i);
            resp_data  = 32'hA000_0000 + 32'(i);
            tick();
            tests++; if (out_valid !== 1'b1 || out_id !== ID_W'(i) || out_data !== 32'hA000_0000 + 32'(i)) begin
                failed++; $display("FAIL inord_retire v=%b id=%0d data=%h exp v=1 id=%0d data=%h", out_valid, out_id, out_data, i, 32'hA000_0000 + 32'(i));
            end
        end
        resp_valid = 1'b0;
        tick();
        tests++; if (out_valid !== 1'b0 || outstanding !== 4'd0 || senior_valid !== 1'b0) begin
            failed++; $display("FAIL inord_drain v=%b outst=%0d sv=%b exp 0/0/0", out_valid, outstanding, senior_valid);
        end
        clear_inputs();
    endtask

    task automatic test_out_of_order();
        int order  [7];
        int exp_ms [7];
        order  = '{4, 0, 1, 3, 5, 6, 2};
        exp_ms = '{0, 0, 1, 2, 2, 2, 2};
        apply_reset();
        out_ready   = 1'b1;
        alloc_valid = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        alloc_valid = 1'b0;
        tests++; if (outstanding !== 4'd7) begin failed++; $display("FAIL ooo_outstanding got=%0d exp=7", outstanding); end
        for (int i = 0; i < 7; i++) begin
            resp_valid = 1'b1;
            resp_id    = ID_W'(order[i]);
            resp_data  = 32'hB000_0000 + 32'(order[i]);
            tick();
            tests++; if (most_senior_id !== ID_W'(exp_ms[i])) begin
                failed++; $display("FAIL ooo_senior step=%0d got=%0d exp=%0d", i, most_senior_id, exp_ms[i]);
            end
        end
        resp_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tests++; if (out_valid !== 1'b1 || out_id !== ID_W'(2 + k) || out_data !== 32'hB000_0000 + 32'(2 + k)) begin
                failed++; $display("FAIL ooo_burst v=%b id=%0d data=%h exp v=1 id=%0d", out_valid, out_id, out_data, 2 + k);
            end
            tick();
        end
        tests++; if (outstanding !== 4'd0 || senior_valid !== 1'b0 || most_senior_id !== 3'd7) begin
            failed++; $display("FAIL ooo_end outst=%0d sv=%b ms=%0d exp 0/0/7", outstanding, senior_valid, most_senior_id);
        end
        clear_inputs();
    endtask

    task automatic test_full_wrap();
        apply_reset();
        alloc_valid = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        tests++; if (alloc_ready !== 1'b0 || outstanding !== 4'd8) begin
            failed++; $display("FAIL full_state ready=%b outst=%0d exp 0/8", alloc_ready, outstanding);
        end
        tick();
        alloc_valid = 1'b0;
        tests++; if (outstanding !== 4'd8) begin failed++; $display("FAIL full_no_alloc outst=%0d exp=8", outstanding); end
        out_ready  = 1'b1;
        resp_valid = 1'b1;
        resp_id    = 3'd0;
        resp_data  = 32'hC0C0_C0C0;
        tick();
        resp_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || alloc_ready !== 1'b0) begin
            failed++; $display("FAIL full_no_bypass v=%b ready=%b exp 1/0", out_valid, alloc_ready);
        end
        tick();
        tests++; if (alloc_ready !== 1'b1 || alloc_id !== 3'd0 || outstanding !== 4'd7) begin
            failed++; $display("FAIL wrap_free ready=%b id=%0d outst=%0d exp 1/0/7", alloc_ready, alloc_id, outstanding);
        end
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        tests++; if (alloc_ready !== 1'b0 || outstanding !== 4'd8 || most_senior_id !== 3'd1) begin
            failed++; $display("FAIL wrap_refill ready=%b outst=%0d ms=%0d exp 0/8/1", alloc_ready, outstanding, most_senior_id);
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        apply_reset();
        alloc_valid = 1'b1;
        tick();
        tick();
        alloc_valid = 1'b0;
        resp_valid  = 1'b1;
        resp_id     = 3'd0;
        resp_data   = 32'h5A5A_0001;
        tick();
        resp_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tests++; if (out_valid !== 1'b1 || out_id !== 3'd0 || out_data !== 32'h5A5A_0001) begin
                failed++; $display("FAIL bp_hold cyc=%0d v=%b id=%0d data=%h exp 1/0/5a5a0001", c, out_valid, out_id, out_data);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        tests++; if (out_valid !== 1'b0 || outstanding !== 4'd1 || most_senior_id !== 3'd1) begin
            failed++; $display("FAIL bp_release v=%b outst=%0d ms=%0d exp 0/1/1", out_valid, outstanding, most_senior_id);
        end
        clear_inputs();
    endtask

    task automatic test_errors();
        apply_reset();
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        resp_valid  = 1'b1;
        resp_id     = 3'd5;
        resp_data   = 32'hDEAD_BEEF;
        tick();
        resp_valid = 1'b0;
        tests++; if (err_unexp_resp !== 1'b1 || outstanding !== 4'd1 || out_valid !== 1'b0) begin
            failed++; $display("FAIL err_free err=%b outst=%0d v=%b exp 1/1/0", err_unexp_resp, outstanding, out_valid);
        end
        tick();
        tests++; if (err_unexp_resp !== 1'b0) begin failed++; $display("FAIL err_pulse_len got=%b exp=0", err_unexp_resp); end
        resp_valid = 1'b1;
        resp_id    = 3'd0;
        resp_data  = 32'h1111_1111;
        tick();
        tests++; if (err_unexp_resp !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h1111_1111) begin
            failed++; $display("FAIL err_good err=%b v=%b data=%h exp 0/1/11111111", err_unexp_resp, out_valid, out_data);
        end
        resp_data = 32'h2222_2222;
        tick();
        resp_valid = 1'b0;
        tests++; if (err_unexp_resp !== 1'b1 || out_data !== 32'h1111_1111) begin
            failed++; $display("FAIL err_dup err=%b data=%h exp 1/11111111", err_unexp_resp, out_data);
        end
        tick();
        tests++; if (err_unexp_resp !== 1'b0 || out_data !== 32'h1111_1111) begin
            failed++; $display("FAIL err_dup_after err=%b data=%h exp 0/11111111", err_unexp_resp, out_data);
        end
        alloc_valid = 1'b1;
        out_ready   = 1'b1;
        resp_valid  = 1'b1;
        resp_id     = 3'd1;
        resp_data   = 32'h3333_3333;
        tick();
        alloc_valid = 1'b0;
        resp_valid  = 1'b0;
        tests++; if (err_unexp_resp !== 1'b1 || outstanding !== 4'd1 || most_senior_id !== 3'd1 || out_valid !== 1'b0) begin
            failed++; $display("FAIL err_same_cycle err=%b outst=%0d ms=%0d v=%b exp 1/1/1/0", err_unexp_resp, outstanding, most_senior_id, out_valid);
        end
        resp_valid = 1'b1;
        tick();
        resp_valid = 1'b0;
        tests++; if (err_unexp_resp !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h3333_3333) begin
            failed++; $display("FAIL err_recover err=%b v=%b data=%h exp 0/1/33333333", err_unexp_resp, out_valid, out_data);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        alloc_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        alloc_valid = 1'b0;
        resp_valid  = 1'b1;
        resp_id     = 3'd1;
        resp_data   = 32'h0000_0011;
        tick();
        resp_id   = 3'd3;
        resp_data = 32'h0000_0033;
        tick();
        resp_valid = 1'b0;
        tests++; if (outstanding !== 4'd5 || out_valid !== 1'b0 || senior_valid !== 1'b1) begin
            failed++; $display("FAIL mid_pre outst=%0d v=%b sv=%b exp 5/0/1", outstanding, out_valid, senior_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        tests++; if (outstanding !== 4'd0) begin failed++; $display("FAIL mid_async outst=%0d exp=0", outstanding); end
        tick();
        tests++; if (alloc_ready !== 1'b1 || alloc_id !== 3'd0 || out_valid !== 1'b0 || senior_valid !== 1'b0 ||
                     most_senior_id !== 3'd0 || outstanding !== 4'd0 || err_unexp_resp !== 1'b0) begin
            failed++; $display("FAIL mid_reset rdy=%b aid=%0d v=%b sv=%b ms=%0d outst=%0d err=%b", alloc_ready, alloc_id,
                               out_valid, senior_valid, most_senior_id, outstanding, err_unexp_resp);
        end
        reset       = 1'b0;
        alloc_valid = 1'b1;
        tests++; if (alloc_id !== 3'd0) begin failed++; $display("FAIL mid_first_id got=%0d exp=0", alloc_id); end
        tick();
        alloc_valid = 1'b0;
        resp_valid  = 1'b1;
        resp_id     = 3'd1;
        tick();
        resp_valid = 1'b0;
        tests++; if (err_unexp_resp !== 1'b1 || outstanding !== 4'd1 || out_valid !== 1'b0) begin
            failed++; $display("FAIL mid_discard err=%b outst=%0d v=%b exp 1/1/0", err_unexp_resp, outstanding, out_valid);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_out_of_order();
        test_full_wrap();
        test_backpressure();
        test_errors();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
